ldq_violation_detect: RTL and testbench

- Consumes the per-entry match vector produced by the partitioned load-queue address CAM when a store address is searched against the LDQ.
- Filters matches down to loads that are younger than the store and have already executed, and picks the oldest such load.
- Holds a memory-ordering violation request, naming that load, until the recovery/commit logic acknowledges it.
- Tracks per-entry "executed" state internally and honours LSQ partition gating.

---
 rtl/ldq_violation_detect.sv | 125 ++++++++++++
 tb/tb_ldq_violation_detect.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldq_violation_detect.sv
// Store-vs-load ordering check: filters CAM matches to executed, younger, powered loads and holds the oldest as a request.
// Latency: search to violation_o takes 2 edges; a search is accepted every cycle; the request is held until violationAck_i or recover_i.
module ldq_violation_detect #(
  parameter int DEPTH     = 32,
  parameter int INDEX     = 5,
  parameter int NUM_PARTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PARTS-1:0] lsqPartitionActive_i,
  input  logic [INDEX-1:0]     ldqHead_i,
  input  logic [INDEX-1:0]     ldqTail_i,
  input  logic                 ldExec_i,
  input  logic [INDEX-1:0]     ldExecIdx_i,
  input  logic                 ldCommit_i,
  input  logic                 recover_i,
  input  logic                 stSearch_i,
  input  logic [INDEX-1:0]     stLdqStart_i,
  input  logic [DEPTH-1:0]     vect_i,
  output logic                 violation_o,
  output logic [INDEX-1:0]     violationIdx_o,
  input  logic                 violationAck_i
);

  localparam int PART_SZ = DEPTH / NUM_PARTS;

  logic [DEPTH-1:0] r_executed;
  logic [DEPTH-1:0] w_exec_nxt;
  logic [DEPTH-1:0] w_win;
  logic [DEPTH-1:0] w_part;
  logic [INDEX-1:0] w_win_len;

  logic [DEPTH-1:0] r_s1_vec;
  logic [INDEX-1:0] r_s1_start;
  logic             r_s1_valid;

  logic             w_hit;
  logic [INDEX-1:0] w_idx;
  logic [INDEX-1:0] w_new_age;
  logic [INDEX-1:0] w_cur_age;
  logic             w_older;

  logic             r_vld;
  logic [INDEX-1:0] r_idx;

  assign w_win_len = ldqTail_i - stLdqStart_i;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    localparam logic [INDEX-1:0] LP_I = INDEX'(gi);
    assign w_win[gi]  = (LP_I - stLdqStart_i) < w_win_len;
    assign w_part[gi] = lsqPartitionActive_i[gi / PART_SZ];
  end

  // Set after clear so an exec to the retiring head index keeps its bit.
  always_comb begin
    w_exec_nxt = r_executed;
    if (ldCommit_i) w_exec_nxt[ldqHead_i] = 1'b0;
    if (ldExec_i)   w_exec_nxt[ldExecIdx_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_executed <= '0;
    end else if (recover_i) begin
      r_executed <= '0;
    end else begin
      r_executed <= w_exec_nxt;
    end
  end

  // Stage 1 samples the pre-update executed bits; same-cycle executors are covered by forwarding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vec   <= '0;
      r_s1_start <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_vec   <= vect_i & r_executed & w_win & w_part;
      r_s1_start <= stLdqStart_i;
      r_s1_valid <= stSearch_i & ~recover_i;
    end
  end

  // Scan downward so the lowest circular offset from s1Start is the last to be taken.
  always_comb begin
    logic [INDEX-1:0] v_pos;
    v_pos = '0;
    w_idx = '0;
    w_hit = |r_s1_vec;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      v_pos = r_s1_start + INDEX'(k);
      if (r_s1_vec[v_pos]) w_idx = v_pos;
    end
  end

  assign w_new_age = w_idx - ldqHead_i;
  assign w_cur_age = r_idx - ldqHead_i;
  assign w_older   = w_new_age < w_cur_age;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_idx <= '0;
    end else if (recover_i) begin
      r_vld <= 1'b0;
    end else if (!r_vld) begin
      if (r_s1_valid && w_hit) begin
        r_vld <= 1'b1;
        r_idx <= w_idx;
      end
    end else if (violationAck_i) begin
      if (r_s1_valid && w_hit) begin
        r_idx <= w_idx;
      end else begin
        r_vld <= 1'b0;
      end
    end else if (r_s1_valid && w_hit && w_older) begin
      r_idx <= w_idx;
    end
  end

  assign violation_o    = r_vld;
  assign violationIdx_o = r_idx;

endmodule

// File: tb/tb_ldq_violation_detect.sv
// Bench for ldq_violation_detect: directed scenarios against fixed expectations, then random traffic against an age-based model.
module tb_ldq_violation_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  lsqPartitionActive_i;
  logic [4:0]  ldqHead_i, ldqTail_i, ldExecIdx_i, stLdqStart_i;
  logic        ldExec_i, ldCommit_i, recover_i, stSearch_i, violationAck_i;
  logic [31:0] vect_i;
  logic        violation_o;
  logic [4:0]  violationIdx_o;

  int total = 0;
  int bad   = 0;

  ldq_violation_detect #(.DEPTH(32), .INDEX(5), .NUM_PARTS(4)) dut (
    .clk(clk), .reset(reset),
    .lsqPartitionActive_i(lsqPartitionActive_i),
    .ldqHead_i(ldqHead_i), .ldqTail_i(ldqTail_i),
    .ldExec_i(ldExec_i), .ldExecIdx_i(ldExecIdx_i),
    .ldCommit_i(ldCommit_i), .recover_i(recover_i),
    .stSearch_i(stSearch_i), .stLdqStart_i(stLdqStart_i), .vect_i(vect_i),
    .violation_o(violation_o), .violationIdx_o(violationIdx_o),
    .violationAck_i(violationAck_i)
  );

  always #5 clk = ~clk;

  // Reference model: oldest candidate = smallest circular distance from the store's start index.
  bit m_exec [32];
  bit m_s1_valid, m_s1_hit, m_vld;
  int m_s1_idx, m_idx;

  always @(posedge clk or negedge reset) begin
    int best_d, best_i, d, len;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_exec[i] = 1'b0;
      m_s1_valid = 0; m_s1_hit = 0; m_s1_idx = 0; m_vld = 0; m_idx = 0;
    end else begin
      if (recover_i) m_vld = 0;
      else if (m_s1_valid && m_s1_hit) begin
        if (!m_vld || violationAck_i) begin
          m_vld = 1; m_idx = m_s1_idx;
        end else if (((m_s1_idx - int'(ldqHead_i)) & 31) < ((m_idx - int'(ldqHead_i)) & 31)) begin
          m_idx = m_s1_idx;
        end
      end else if (m_vld && violationAck_i) m_vld = 0;

      best_d = 32; best_i = 0;
      len = (int'(ldqTail_i) - int'(stLdqStart_i)) & 31;
      for (int i = 0; i < 32; i++) begin
        d = (i - int'(stLdqStart_i)) & 31;
        if (vect_i[i] && m_exec[i] && d < len && lsqPartitionActive_i[i / 8] && d < best_d) begin
          best_d = d; best_i = i;
        end
      end
      m_s1_hit   = best_d < 32;
      m_s1_idx   = best_i;
      m_s1_valid = stSearch_i && !recover_i;

      if (recover_i) for (int i = 0; i < 32; i++) m_exec[i] = 1'b0;
      else begin
        if (ldCommit_i) m_exec[ldqHead_i] = 1'b0;
        if (ldExec_i)   m_exec[ldExecIdx_i] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_exec(input int idx);
    ldExec_i = 1'b1; ldExecIdx_i = idx[4:0];
    tick();
    ldExec_i = 1'b0;
  endtask

  task automatic do_search(input int start, input logic [31:0] v);
    stSearch_i = 1'b1; stLdqStart_i = start[4:0]; vect_i = v;
    tick();
    stSearch_i = 1'b0; vect_i = '0;
  endtask

  task automatic cleanup();
    violationAck_i = 1'b0;
    recover_i = 1'b1;
    tick();
    recover_i = 1'b0;
    lsqPartitionActive_i = 4'hF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++;
    if (violation_o !== 1'b0 || violationIdx_o !== 5'd0) begin
      bad++; $display("FAIL reset got vld=%0b idx=%0d want vld=0 idx=0", violation_o, violationIdx_o);
    end
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_exec(3); do_exec(5); do_exec(7);
    ldqHead_i = 5'd2; ldqTail_i = 5'd10;
    do_search(4, 32'h0000_00A8);
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL basic_edge1 got vld=%0b want 0", violation_o);
    end
    tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd5) begin
      bad++; $display("FAIL basic_hit got vld=%0b idx=%0d want vld=1 idx=5", violation_o, violationIdx_o);
    end
    violationAck_i = 1'b1; tick(); violationAck_i = 1'b0;
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL basic_ack got vld=%0b want 0", violation_o);
    end
    cleanup();
  endtask

  task automatic test_wrap();
    ldqHead_i = 5'd28; ldqTail_i = 5'd4;
    do_exec(30); do_exec(1);
    do_search(29, (32'd1 << 1) | (32'd1 << 30));
    tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd30) begin
      bad++; $display("FAIL wrap got vld=%0b idx=%0d want vld=1 idx=30", violation_o, violationIdx_o);
    end
    cleanup();
  endtask

  task automatic test_filter();
    ldqHead_i = 5'd0; ldqTail_i = 5'd10;
    do_search(4, 32'd1 << 6);
    tick();
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL not_executed got vld=%0b want 0", violation_o);
    end
    do_exec(6); do_exec(7);
    ldqTail_i = 5'd6;
    do_search(6, 32'hFFFF_FFFF);
    tick();
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL empty_window got vld=%0b want 0", violation_o);
    end
    cleanup();
  endtask

  task automatic test_partition();
    lsqPartitionActive_i = 4'b1101;
    ldqHead_i = 5'd0; ldqTail_i = 5'd20;
    do_exec(10);
    do_search(5, 32'd1 << 10);
    tick();
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL part_gated got vld=%0b want 0", violation_o);
    end
    lsqPartitionActive_i = 4'b1111;
    do_search(5, 32'd1 << 10);
    tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd10) begin
      bad++; $display("FAIL part_active got vld=%0b idx=%0d want vld=1 idx=10", violation_o, violationIdx_o);
    end
    cleanup();
  endtask

  task automatic test_replace();
    ldqHead_i = 5'd0; ldqTail_i = 5'd20;
    do_exec(8); do_exec(12); do_exec(15);
    do_search(1, 32'd1 << 12); tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd12) begin
      bad++; $display("FAIL repl_first got vld=%0b idx=%0d want vld=1 idx=12", violation_o, violationIdx_o);
    end
    do_search(1, 32'd1 << 8); tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd8) begin
      bad++; $display("FAIL repl_older got vld=%0b idx=%0d want vld=1 idx=8", violation_o, violationIdx_o);
    end
    do_search(1, 32'd1 << 15); tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd8) begin
      bad++; $display("FAIL repl_younger got vld=%0b idx=%0d want vld=1 idx=8", violation_o, violationIdx_o);
    end
    do_search(1, 32'd1 << 15);
    violationAck_i = 1'b1; tick(); violationAck_i = 1'b0;
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd15) begin
      bad++; $display("FAIL repl_ack_hit got vld=%0b idx=%0d want vld=1 idx=15", violation_o, violationIdx_o);
    end
  endtask

  task automatic test_recover();
    do_search(1, 32'd1 << 8);
    recover_i = 1'b1; tick(); recover_i = 1'b0;
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL recover_pending got vld=%0b want 0", violation_o);
    end
    do_search(0, 32'hFFFF_FFFF); tick();
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL recover_exec_clear got vld=%0b want 0", violation_o);
    end
    cleanup();
  endtask

  task automatic test_exec_commit();
    ldqHead_i = 5'd0; ldqTail_i = 5'd20;
    do_exec(11);
    ldqHead_i = 5'd11; ldCommit_i = 1'b1; tick();
    ldqHead_i = 5'd9; ldExec_i = 1'b1; ldExecIdx_i = 5'd9; tick();
    ldCommit_i = 1'b0; ldExec_i = 1'b0; ldqHead_i = 5'd0;
    do_search(0, 32'd1 << 11); tick();
    total++;
    if (violation_o !== 1'b0) begin
      bad++; $display("FAIL commit_clears got vld=%0b want 0", violation_o);
    end
    do_search(0, 32'd1 << 9); tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd9) begin
      bad++; $display("FAIL exec_wins got vld=%0b idx=%0d want vld=1 idx=9", violation_o, violationIdx_o);
    end
    cleanup();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      ldqHead_i      = 5'($urandom);
      ldqTail_i      = 5'($urandom);
      ldExec_i       = ($urandom_range(0, 1) == 1);
      ldExecIdx_i    = 5'($urandom);
      ldCommit_i     = ($urandom_range(0, 3) == 0);
      recover_i      = ($urandom_range(0, 31) == 0);
      stSearch_i     = ($urandom_range(0, 1) == 1);
      stLdqStart_i   = 5'($urandom);
      vect_i         = $urandom;
      violationAck_i = ($urandom_range(0, 3) == 0);
      lsqPartitionActive_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick();
      total++;
      if (violation_o !== m_vld || (m_vld && violationIdx_o !== 5'(m_idx))) begin
        bad++;
        $display("FAIL random_%0d got vld=%0b idx=%0d want vld=%0b idx=%0d",
                 n, violation_o, violationIdx_o, m_vld, m_idx);
      end
    end
    ldExec_i = 0; ldCommit_i = 0; stSearch_i = 0; vect_i = '0;
    cleanup();
  endtask

  task automatic test_async_reset();
    ldqHead_i = 5'd0; ldqTail_i = 5'd10;
    do_exec(3);
    do_search(1, 32'd1 << 3); tick();
    total++;
    if (violation_o !== 1'b1 || violationIdx_o !== 5'd3) begin
      bad++; $display("FAIL areset_setup got vld=%0b idx=%0d want vld=1 idx=3", violation_o, violationIdx_o);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (violation_o !== 1'b0 || violationIdx_o !== 5'd0) begin
      bad++; $display("FAIL areset_immediate got vld=%0b idx=%0d want vld=0 idx=0", violation_o, violationIdx_o);
    end
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; lsqPartitionActive_i = 4'hF;
    ldqHead_i = '0; ldqTail_i = '0; ldExec_i = 0; ldExecIdx_i = '0;
    ldCommit_i = 0; recover_i = 0; stSearch_i = 0; stLdqStart_i = '0;
    vect_i = '0; violationAck_i = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_filter();
    test_partition();
    test_replace();
    test_recover();
    test_exec_commit();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
